// File: rtl/prmcu_uart_pkg.sv
// Shared UART types, frame limits and parity helpers.
// The receiver and the transmitter both use this package.
package prmcu_uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_t;

  localparam int unsigned MIN_DATA_BITS = 5;
  localparam int unsigned MAX_DATA_BITS = 9;
  localparam int unsigned MIN_CLK_DIV   = 2;

  function automatic logic [8:0] width_mask(input logic [3:0] n_bits);
    logic [8:0] mask;
    mask = '0;
    for (int i = 0; i < 9; i++) begin
      mask[i] = (4'(i) < n_bits);
    end
    return mask;
  endfunction

  // Returns 1 when the masked word holds an odd number of ones.
  function automatic logic even_parity(input logic [8:0] data, input logic [8:0] mask);
    return ^(data & mask);
  endfunction

endpackage

// File: rtl/prmcu_sync_ff.sv
// Multi-flop synchronizer for an asynchronous level input.
// All flops preset to 1, which matches the UART idle level.
module prmcu_sync_ff #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [SYNC_STAGES-1:0] ff_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ff_q <= '1;
    end else begin
      ff_q <= {ff_q[SYNC_STAGES-2:0], d};
    end
  end

  assign q = ff_q[SYNC_STAGES-1];

endmodule

// File: rtl/prmcu_uart_rx.sv
// UART receiver: 5-9 data bits, optional even parity, 1-2 stop bits,
// single-entry valid/ready output register with overrun reporting.
//
// state  | meaning
// IDLE   | waiting for a falling edge on rx_s (and the line high after a break)
// START  | timing to mid start bit; a high sample there is a glitch
// DATA   | sampling data bits LSB first, one per bit period
// PARITY | sampling the even parity bit
// STOP   | sampling stop bits; the last one completes the frame
module prmcu_uart_rx
  import prmcu_uart_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DAT_W       = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             uart_en,
  input  logic             rx_en,
  input  logic             n_parity_bits,
  input  logic [1:0]       n_stop_bits,
  input  logic [3:0]       n_data_bits,
  input  logic [7:0]       internal_clk_divider,
  output logic [DAT_W-1:0] out_dat_o,
  output logic             out_vld_o,
  input  logic             out_rdy_i,
  output logic             parity_err_o,
  output logic             frame_err_o,
  output logic             overrun_o,
  output logic             busy_o,
  input  logic             rx_i
);

  rx_state_t  state_q, state_d;
  logic       rx_s, rx_d;
  logic       en, fall, strobe, start_go, complete, frm_err_now;
  logic [8:0] baud_cnt_q, strobe_cmp;
  logic [7:0] cfg_div_q;
  logic [3:0] cfg_nbits_q, bit_cnt_q;
  logic       cfg_par_q, cfg_stop2_q;
  logic       stop_cnt_q, brk_wait_q;
  logic [8:0] shreg_q;
  logic       par_err_q, frm_err_q;

  prmcu_sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk (clk),
    .rst (rst),
    .d   (rx_i),
    .q   (rx_s)
  );

  assign en         = uart_en & rx_en;
  assign fall       = rx_d & ~rx_s;
  // Half a bit period in START lands the remaining samples at mid-bit.
  assign strobe_cmp = (state_q == START) ? ({1'b0, cfg_div_q} - 9'd1)
                                         : ({cfg_div_q, 1'b0} - 9'd1);
  assign strobe      = (baud_cnt_q == strobe_cmp);
  assign frm_err_now = stop_cnt_q ? frm_err_q : ~rx_s;
  assign busy_o      = (state_q != IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    start_go = 1'b0;
    complete = 1'b0;
    if (!en) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (fall && !brk_wait_q) begin
            state_d  = START;
            start_go = 1'b1;
          end
        end
        START: begin
          if (strobe) state_d = rx_s ? IDLE : DATA;
        end
        DATA: begin
          if (strobe && (bit_cnt_q == cfg_nbits_q - 4'd1)) begin
            state_d = cfg_par_q ? PARITY : STOP;
          end
        end
        PARITY: begin
          if (strobe) state_d = STOP;
        end
        STOP: begin
          if (strobe && (stop_cnt_q || !cfg_stop2_q)) begin
            state_d  = IDLE;
            complete = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_d        <= 1'b1;
      baud_cnt_q  <= '0;
      cfg_div_q   <= 8'(MIN_CLK_DIV);
      cfg_nbits_q <= 4'(MIN_DATA_BITS);
      cfg_par_q   <= 1'b0;
      cfg_stop2_q <= 1'b0;
      bit_cnt_q   <= '0;
      stop_cnt_q  <= 1'b0;
      shreg_q     <= '0;
      par_err_q   <= 1'b0;
      frm_err_q   <= 1'b0;
      brk_wait_q  <= 1'b0;
    end else begin
      rx_d <= rx_s;

      if (state_q == IDLE || strobe) begin
        baud_cnt_q <= '0;
      end else begin
        baud_cnt_q <= baud_cnt_q + 9'd1;
      end

      if (start_go) begin
        cfg_div_q   <= (internal_clk_divider < 8'(MIN_CLK_DIV)) ? 8'(MIN_CLK_DIV)
                                                                : internal_clk_divider;
        cfg_nbits_q <= (n_data_bits < 4'(MIN_DATA_BITS)) ? 4'(MIN_DATA_BITS) :
                       (n_data_bits > 4'(MAX_DATA_BITS)) ? 4'(MAX_DATA_BITS) :
                                                           n_data_bits;
        cfg_par_q   <= n_parity_bits;
        cfg_stop2_q <= n_stop_bits[1];
        bit_cnt_q   <= '0;
        stop_cnt_q  <= 1'b0;
        shreg_q     <= '0;
        par_err_q   <= 1'b0;
        frm_err_q   <= 1'b0;
      end

      if (state_q == DATA && strobe) begin
        shreg_q[bit_cnt_q] <= rx_s;
        bit_cnt_q          <= bit_cnt_q + 4'd1;
      end

      if (state_q == PARITY && strobe) begin
        par_err_q <= even_parity(shreg_q, width_mask(cfg_nbits_q)) ^ rx_s;
      end

      if (state_q == STOP && strobe) begin
        stop_cnt_q <= 1'b1;
        if (!stop_cnt_q) frm_err_q <= ~rx_s;
      end

      // After a framing error the line may sit low (break); wait for it to go high.
      if (complete) begin
        brk_wait_q <= frm_err_now;
      end else if (state_q == IDLE && rx_s) begin
        brk_wait_q <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_dat_o    <= '0;
      out_vld_o    <= 1'b0;
      parity_err_o <= 1'b0;
      frame_err_o  <= 1'b0;
      overrun_o    <= 1'b0;
    end else begin
      overrun_o <= 1'b0;
      if (complete) begin
        if (!out_vld_o || out_rdy_i) begin
          out_dat_o    <= DAT_W'(shreg_q);
          parity_err_o <= par_err_q;
          frame_err_o  <= frm_err_now;
          out_vld_o    <= 1'b1;
        end else begin
          overrun_o <= 1'b1;
        end
      end else if (out_vld_o && out_rdy_i) begin
        out_vld_o <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_prmcu_uart_rx.sv
// Self-checking bench for prmcu_uart_rx: directed frames plus randomized
// frames checked against a frame-level reference model.
module tb_prmcu_uart_rx;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       uart_en = 1'b0, rx_en = 1'b0, n_parity_bits = 1'b0;
  logic [1:0] n_stop_bits = 2'd1;
  logic [3:0] n_data_bits = 4'd8;
  logic [7:0] internal_clk_divider = 8'd43;
  logic [8:0] out_dat_o;
  logic       out_vld_o, out_rdy_i = 1'b0, parity_err_o, frame_err_o, overrun_o, busy_o;
  logic       rx_i = 1'b1;

  int checks = 0, errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int rd_idx = 0;
  int ovr_cnt = 0, vld_cycles = 0, vld_rise = 0;
  logic vld_prev = 1'b0;
  logic [10:0] got_q[$];

  prmcu_uart_rx #(.SYNC_STAGES(2), .DAT_W(9)) dut (
    .clk                  (clk),
    .rst                  (rst),
    .uart_en              (uart_en),
    .rx_en                (rx_en),
    .n_parity_bits        (n_parity_bits),
    .n_stop_bits          (n_stop_bits),
    .n_data_bits          (n_data_bits),
    .internal_clk_divider (internal_clk_divider),
    .out_dat_o            (out_dat_o),
    .out_vld_o            (out_vld_o),
    .out_rdy_i            (out_rdy_i),
    .parity_err_o         (parity_err_o),
    .frame_err_o          (frame_err_o),
    .overrun_o            (overrun_o),
    .busy_o               (busy_o),
    .rx_i                 (rx_i)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: records accepted words {frame_err, parity_err, data}.
  always @(negedge clk) begin
    #1;
    if (rst) begin
      if (out_vld_o && out_rdy_i) got_q.push_back({frame_err_o, parity_err_o, out_dat_o});
      if (overrun_o) ovr_cnt++;
      if (out_vld_o) vld_cycles++;
      if (out_vld_o && !vld_prev) vld_rise = cyc;
    end
    vld_prev = out_vld_o;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic expect_word(input string tag, input logic [10:0] exp);
    chk({tag, "_cnt"}, 32'(got_q.size() - rd_idx), 32'd1);
    if (got_q.size() > rd_idx) chk(tag, 32'(got_q[rd_idx]), 32'(exp));
    rd_idx = got_q.size();
  endtask

  function automatic logic [8:0] nmask(input int nb);
    return 9'((1 << nb) - 1);
  endfunction

  function automatic int eff_nb(input int raw);
    return (raw < 5) ? 5 : (raw > 9) ? 9 : raw;
  endfunction

  // Drives one frame; nb/ns/div are the effective frame parameters.
  task automatic send_frame(input logic [8:0] data, input int nb, input bit par_en,
                            input bit par_bad, input int ns, input bit stop1,
                            input bit stop2, input int div, input int gap_bits,
                            input bit scramble);
    int bp;
    logic [7:0] s_div;
    logic [3:0] s_nb;
    logic [1:0] s_ns;
    logic       s_par;
    bp = 2 * div;
    s_div = internal_clk_divider; s_nb = n_data_bits; s_ns = n_stop_bits; s_par = n_parity_bits;
    @(negedge clk);
    rx_i = 1'b0;
    start_cyc = cyc;
    repeat (4) @(negedge clk);
    if (scramble) begin
      internal_clk_divider = 8'($urandom_range(0, 255));
      n_data_bits = 4'($urandom_range(0, 15));
      n_stop_bits = 2'($urandom_range(0, 3));
      n_parity_bits = 1'($urandom_range(0, 1));
    end
    repeat (bp - 4) @(negedge clk);
    for (int i = 0; i < nb; i++) begin
      rx_i = data[i];
      repeat (bp) @(negedge clk);
    end
    if (par_en) begin
      rx_i = (^(data & nmask(nb))) ^ par_bad;
      repeat (bp) @(negedge clk);
    end
    rx_i = stop1;
    repeat (bp) @(negedge clk);
    if (ns == 2) begin
      rx_i = stop2;
      repeat (bp) @(negedge clk);
    end
    internal_clk_divider = s_div; n_data_bits = s_nb; n_stop_bits = s_ns; n_parity_bits = s_par;
    rx_i = 1'b1;
    repeat (gap_bits * bp) @(negedge clk);
  endtask

  initial begin
    int vb, ob, r_nb, r_div, r_ns, e_nb, e_div, e_ns;
    bit r_par, p_bad, s1, s2;
    logic [8:0] d;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_vld", 32'(out_vld_o), 32'd0);
    chk("rst_dat", 32'(out_dat_o), 32'd0);
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_flags", 32'({parity_err_o, frame_err_o, overrun_o}), 32'd0);
    rst = 1'b1; uart_en = 1'b1; rx_en = 1'b1; out_rdy_i = 1'b1;
    repeat (5) @(negedge clk);

    // 8N1 0xA5 at divider 43: data, flags, latency and single valid cycle
    internal_clk_divider = 8'd43; n_data_bits = 4'd8; n_parity_bits = 1'b0; n_stop_bits = 2'd1;
    vb = vld_cycles;
    send_frame(9'h0A5, 8, 0, 0, 1, 1, 1, 43, 2, 0);
    expect_word("t1_word", {2'b00, 9'h0A5});
    chk("t1_latency", 32'(vld_rise), 32'(start_cyc + 3 + 43 + 9 * 86));
    chk("t1_vld_cycles", 32'(vld_cycles - vb), 32'd1);

    // 9E2 0x1C3, good then bad parity
    n_data_bits = 4'd9; n_parity_bits = 1'b1; n_stop_bits = 2'd2;
    send_frame(9'h1C3, 9, 1, 0, 2, 1, 1, 43, 2, 0);
    expect_word("t2_par_ok", {2'b00, 9'h1C3});
    send_frame(9'h1C3, 9, 1, 1, 2, 1, 1, 43, 2, 0);
    expect_word("t2_par_bad", {2'b01, 9'h1C3});

    // Framing error followed by a 20-bit break
    n_data_bits = 4'd8; n_parity_bits = 1'b0; n_stop_bits = 2'd1;
    send_frame(9'h03C, 8, 0, 0, 1, 0, 1, 43, 0, 0);
    rx_i = 1'b0;
    repeat (20 * 86) @(negedge clk);
    expect_word("t3_break", {2'b10, 9'h03C});
    rx_i = 1'b1;
    repeat (2 * 86) @(negedge clk);
    send_frame(9'h055, 8, 0, 0, 1, 1, 1, 43, 2, 0);
    expect_word("t3_after", {2'b00, 9'h055});

    // Overrun: three back-to-back frames while the consumer stalls
    out_rdy_i = 1'b0;
    ob = ovr_cnt;
    send_frame(9'h011, 8, 0, 0, 1, 1, 1, 43, 0, 0);
    send_frame(9'h022, 8, 0, 0, 1, 1, 1, 43, 0, 0);
    send_frame(9'h033, 8, 0, 0, 1, 1, 1, 43, 1, 0);
    chk("t4_held_vld", 32'(out_vld_o), 32'd1);
    chk("t4_held_dat", 32'(out_dat_o), 32'h011);
    chk("t4_overruns", 32'(ovr_cnt - ob), 32'd2);
    out_rdy_i = 1'b1;
    repeat (4) @(negedge clk);
    expect_word("t4_handshake", {2'b00, 9'h011});
    chk("t4_vld_clear", 32'(out_vld_o), 32'd0);

    // Start-bit glitch of 30 cycles
    @(negedge clk);
    rx_i = 1'b0;
    repeat (20) @(negedge clk);
    chk("t5_busy_in", 32'(busy_o), 32'd1);
    repeat (10) @(negedge clk);
    rx_i = 1'b1;
    repeat (200) @(negedge clk);
    chk("t5_busy_out", 32'(busy_o), 32'd0);
    chk("t5_no_word", 32'(got_q.size() - rd_idx), 32'd0);

    // Reset mid-DATA with a held word
    out_rdy_i = 1'b0;
    send_frame(9'h077, 8, 0, 0, 1, 1, 1, 43, 1, 0);
    chk("t6_held", 32'(out_vld_o), 32'd1);
    rx_i = 1'b0;
    repeat (86) @(negedge clk);
    rx_i = 1'b1;
    repeat (86) @(negedge clk);
    rx_i = 1'b0;
    repeat (40) @(negedge clk);
    chk("t6_busy_pre", 32'(busy_o), 32'd1);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    chk("t6_rst_vld", 32'(out_vld_o), 32'd0);
    chk("t6_rst_dat", 32'(out_dat_o), 32'd0);
    chk("t6_rst_busy", 32'(busy_o), 32'd0);
    rx_i = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b1; out_rdy_i = 1'b1;
    repeat (2 * 86) @(negedge clk);
    send_frame(9'h05A, 8, 0, 0, 1, 1, 1, 43, 2, 0);
    expect_word("t6_after", {2'b00, 9'h05A});

    // Receiver disabled mid-frame
    internal_clk_divider = 8'd10;
    @(negedge clk);
    rx_i = 1'b0;
    repeat (60) @(negedge clk);
    rx_en = 1'b0; rx_i = 1'b1;
    @(negedge clk);
    chk("t7_idle", 32'(busy_o), 32'd0);
    repeat (5) @(negedge clk);
    rx_en = 1'b1;
    repeat (100) @(negedge clk);
    chk("t7_no_word", 32'(got_q.size() - rd_idx), 32'd0);

    // Randomized frames with raw (clamped) configuration, scrambled mid-frame
    for (int k = 0; k < 14; k++) begin
      r_nb  = $urandom_range(0, 15);
      r_div = $urandom_range(0, 12);
      r_ns  = $urandom_range(0, 3);
      r_par = 1'($urandom_range(0, 1));
      d     = 9'($urandom);
      p_bad = ($urandom_range(0, 3) == 0);
      s1    = ($urandom_range(0, 4) != 0);
      s2    = 1'($urandom_range(0, 1));
      e_nb  = eff_nb(r_nb);
      e_div = (r_div < 2) ? 2 : r_div;
      e_ns  = (r_ns >= 2) ? 2 : 1;
      internal_clk_divider = 8'(r_div); n_data_bits = 4'(r_nb);
      n_stop_bits = 2'(r_ns); n_parity_bits = r_par;
      send_frame(d, e_nb, r_par, p_bad, e_ns, s1, s2, e_div, 2, 1);
      expect_word($sformatf("rnd%0d", k), {~s1, r_par & p_bad, d & nmask(e_nb)});
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/prmcu_uart_rx.md
Name: prmcu_uart_rx

Overview:
UART receive path of the prmcu UART; the counterpart of the transmitter inside prmcu_uart_top. It samples the serial rx line, recovers frames of 5-9 data bits with an optional even parity bit and 1-2 stop bits, and presents each received word on a valid/ready output port. Its frame configuration inputs match the transmitter's, so prmcu_uart_top can drive both from the same configuration registers.

Parameters:
SYNC_STAGES, 2, number of flip-flops in the rx input synchronizer (minimum 2).
DAT_W, 9, width of the output data word; this is the largest supported n_data_bits.

Ports:
clk  in  1  system clock (10 MHz nominal).
rst  in  1  reset; asynchronous, active-low.
uart_en  in  1  global UART enable; 0 forces IDLE.
rx_en  in  1  receiver enable; 0 forces IDLE.
n_parity_bits  in  1  0 = no parity, 1 = even parity bit after the data bits.
n_stop_bits  in  2  number of stop bits, 1 or 2; values 0 and 3 are treated as 1 and 2 respectively.
n_data_bits  in  4  data bits per frame, 5..9; values below 5 clamp to 5, values above 9 clamp to 9.
internal_clk_divider  in  8  half bit period in clk cycles; bit period = 2*internal_clk_divider; values 0 and 1 clamp to 2.
out_dat_o  out  DAT_W  received word, LSB-aligned; bits at and above n_data_bits read as 0.
out_vld_o  out  1  out_dat_o and the error flags are valid.
out_rdy_i  in  1  the consumer accepts the word.
parity_err_o  out  1  parity mismatch on the held word; valid while out_vld_o = 1.
frame_err_o  out  1  first stop bit sampled low on the held word; valid while out_vld_o = 1.
overrun_o  out  1  one-cycle pulse when a completed frame is dropped.
busy_o  out  1  1 in every state except IDLE.
rx_i  in  1  serial input; idles high.

Behaviour:
- Reset (rst = 0, asynchronous): state IDLE; all synchronizer flops preset to 1; out_vld_o, out_dat_o, parity_err_o, frame_err_o, overrun_o and busy_o all 0.
- rx_i passes through SYNC_STAGES flops. All sampling uses the synchronized signal rx_s. Edge detection uses rx_s and a one-flop delayed copy.
- One bit counter (baud_cnt) counts clk cycles. A sample strobe fires when baud_cnt reaches internal_clk_divider-1 in START, and 2*internal_clk_divider-1 in every later state. baud_cnt clears on each strobe.
- FSM states and transitions:
  - IDLE -> START on a falling edge of rx_s while uart_en and rx_en are both 1. baud_cnt clears on entry.
  - START: at the mid-bit strobe, rx_s = 0 -> DATA; rx_s = 1 -> IDLE (glitch rejected, no output).
  - DATA: one strobe per bit. Bits shift in LSB first. After n_data_bits strobes -> PARITY if n_parity_bits = 1, otherwise -> STOP.
  - PARITY: one strobe. parity_err = (XOR of the data bits) XOR rx_s, which is 0 for correct even parity.
  - STOP: one strobe per stop bit. frame_err is set if the first stop bit is 0; a second stop bit is sampled but ignored. After the last stop bit, the frame completes and the FSM returns to IDLE.
  - If frame_err = 1, IDLE holds off start detection until rx_s has been seen high for at least one cycle (break handling).
- Output register (single entry):
  - On frame completion with out_vld_o = 0: load out_dat_o, parity_err_o and frame_err_o; out_vld_o = 1 on the next cycle. Completion latency is 1 clk after the last stop-bit strobe.
  - On frame completion with out_vld_o = 1 and out_rdy_i = 0: the new frame is dropped, overrun_o pulses for 1 cycle, and the held word is unchanged.
  - On frame completion in the same cycle as the held word is accepted (out_vld_o & out_rdy_i): the new word loads and out_vld_o stays 1.
  - out_vld_o & out_rdy_i with no completion: out_vld_o = 0 next cycle.
  - Once out_vld_o = 1, out_dat_o and the flags stay stable until the handshake.
- Configuration inputs are captured on IDLE -> START. Changing them mid-frame has no effect on the current frame.
- uart_en or rx_en falling mid-frame: the next cycle is IDLE, the partial frame is discarded, and a held output word is kept.

Decomposition:
- prmcu_uart_pkg holds the shared items: rx_state_t enum {IDLE, START, DATA, PARITY, STOP}, the constants MIN_DATA_BITS = 5, MAX_DATA_BITS = 9 and MIN_CLK_DIV = 2, and a function that computes even parity over a 9-bit word under a width mask. The transmitter reuses the package.
- One sub-module: prmcu_sync_ff, a SYNC_STAGES-deep synchronizer with preset-to-1 reset. Everything else stays in prmcu_uart_rx.

Test Plan:
- Divider 43, 8N1, rx_i driven with 0xA5 at 86 cycles/bit, out_rdy_i = 1 -> out_dat_o = 0x0A5, both error flags 0, one out_vld_o cycle 1 clk after the stop strobe.
- 9E2 (9 data bits, even parity, 2 stop bits), data 0x1C3 sent with parity bit 1 -> out_dat_o = 0x1C3, parity_err_o = 0. The same frame with parity bit 0 -> parity_err_o = 1.
- 8N1 frame 0x3C with its stop bit driven 0, then rx_i held low for 20 bit times -> frame_err_o = 1 and exactly one word. No new frame until rx_i returns high and a fresh start bit arrives.
- out_rdy_i = 0, three back-to-back 8N1 frames 0x11, 0x22, 0x33 -> held word 0x11, overrun_o pulses twice. After out_rdy_i = 1: one handshake of 0x11, then out_vld_o = 0.
- rx_i low pulse of 30 cycles (under 43) -> no output, FSM back in IDLE.
- Reset (rst = 0) asserted mid-DATA, then released, then frame 0x5A -> no output from the aborted frame, 0x5A received correctly.
